// File: rtl/spi_io_expander.sv
// SPI-attached 8-bit GPIO expander: opcode/address/data framing over a
// synchronized SPI mode-0 slave with a small register file.
module spi_io_expander #(
  parameter logic [6:0]  DEV_OPCODE  = 7'b0100000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       spiClk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] gpio_i,
  output logic [7:0] gpio_o,
  output logic [7:0] iodir_o,
  output logic       wr_stb,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int unsigned NREG      = 9;
  localparam logic [3:0]  ADDR_IPOL = 4'h1;
  localparam logic [3:0]  ADDR_GPIO = 4'h9;
  localparam logic [3:0]  ADDR_OLAT = 4'hA;

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA, IGNORE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_assert, cs_deassert;
  logic [2:0]             bit_cnt;
  logic                   byte_done;
  logic [7:0]             shift_in;
  logic [7:0]             shift_out;
  logic                   rd;
  logic                   load_pending;
  logic [3:0]             ptr;
  logic [3:0]             next_ptr;
  logic [7:0]             rd_val;
  logic [7:0]             regs [NREG];
  logic [7:0]             olat;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign cs_assert   = ~cs_s & cs_q;
  assign cs_deassert = cs_s & ~cs_q;

  assign gpio_o  = olat;
  assign iodir_o = regs[0];

  // Read mux; unmapped addresses read as zero
  always_comb begin
    rd_val = 8'h00;
    if (ptr == ADDR_GPIO)      rd_val = gpio_i ^ regs[ADDR_IPOL];
    else if (ptr == ADDR_OLAT) rd_val = olat;
    else if (ptr < ADDR_GPIO)  rd_val = regs[ptr];
  end

  // SEQOP (IOCON[5]) pins the pointer; otherwise wrap past OLAT to IODIR
  always_comb begin
    next_ptr = ptr;
    if (!regs[5][5]) next_ptr = (ptr >= ADDR_OLAT) ? 4'h0 : ptr + 4'h1;
  end

  // Synchronizers and edge-detect history; cs history resets to "asserted"
  // so a frame in flight across reset is never mistaken for a new one.
  always_ff @(posedge sysClk) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spiClk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  // Frame FSM, register file and serial shifters
  always_ff @(posedge sysClk) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      byte_done    <= 1'b0;
      shift_in     <= 8'h00;
      shift_out    <= 8'h00;
      rd           <= 1'b0;
      load_pending <= 1'b0;
      ptr          <= 4'h0;
      miso         <= 1'b0;
      wr_stb       <= 1'b0;
      wr_addr      <= 4'h0;
      wr_data      <= 8'h00;
      olat         <= 8'h00;
      for (int i = 0; i < NREG; i++) regs[i] <= (i == 0) ? 8'hFF : 8'h00;
    end else begin
      wr_stb    <= 1'b0;
      byte_done <= 1'b0;
      if (cs_deassert) begin
        state        <= IDLE;
        bit_cnt      <= 3'd0;
        load_pending <= 1'b0;
        miso         <= 1'b0;
      end else if (cs_assert) begin
        state        <= OPCODE;
        bit_cnt      <= 3'd0;
        load_pending <= 1'b0;
        miso         <= 1'b0;
      end else begin
        if (sclk_rise && (state == OPCODE || state == ADDR || state == DATA)) begin
          shift_in  <= {shift_in[6:0], mosi_s};
          bit_cnt   <= bit_cnt + 3'd1;
          byte_done <= (bit_cnt == 3'd7);
        end
        if (byte_done) begin
          case (state)
            OPCODE: begin
              if (shift_in[7:1] == DEV_OPCODE) begin
                state <= ADDR;
                rd    <= shift_in[0];
              end else begin
                state <= IGNORE;
              end
            end
            ADDR: begin
              ptr          <= shift_in[3:0];
              state        <= DATA;
              load_pending <= rd;
            end
            DATA: begin
              if (rd) begin
                load_pending <= 1'b1;
              end else if (ptr <= ADDR_OLAT) begin
                wr_stb  <= 1'b1;
                wr_data <= shift_in;
                if (ptr >= ADDR_GPIO) begin
                  olat    <= shift_in;
                  wr_addr <= ADDR_OLAT;
                end else begin
                  regs[ptr] <= shift_in;
                  wr_addr   <= ptr;
                end
              end
              ptr <= next_ptr;
            end
            default: ;
          endcase
        end
        if (sclk_fall && state == DATA && rd) begin
          if (load_pending) begin
            shift_out    <= rd_val;
            miso         <= rd_val[7];
            load_pending <= 1'b0;
          end else begin
            shift_out <= {shift_out[6:0], 1'b0};
            miso      <= shift_out[6];
          end
        end
      end
    end
  end

endmodule

// File: doc/spi_io_expander.md
SPI_IO_EXPANDER -- requirements
Module: spi_io_expander

Interface
REQ-001 SHALL expose parameter DEV_OPCODE, default 7'b0100000, the device-address field matched against opcode bits [7:1].
REQ-002 SHALL expose parameter SYNC_STAGES, default 2, the number of synchronizer flops on spiClk, cs and mosi.
REQ-003 SHALL have port sysClk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have port spiClk, input, 1, the SPI clock from the master, asynchronous to sysClk.
REQ-006 SHALL have port cs, input, 1, the chip select, active-low.
REQ-007 SHALL have port mosi, input, 1, serial data from the master.
REQ-008 SHALL have port miso, output, 1, serial data to the master.
REQ-009 SHALL have port gpio_i, input, 8, the external pin levels.
REQ-010 SHALL have port gpio_o, output, 8, the OLAT register contents.
REQ-011 SHALL have port iodir_o, output, 8, the IODIR register contents (1 = input).
REQ-012 SHALL have port wr_stb, output, 1, a one-cycle pulse per committed register write.
REQ-013 SHALL have port wr_addr, output, 4, the address of the committed write.
REQ-014 SHALL have port wr_data, output, 8, the data of the committed write.

Function
REQ-015 SHALL pass spiClk, cs and mosi through SYNC_STAGES flops, then detect spiClk rise/fall and cs assert/deassert from the synchronized values; sysClk is at least 8x spiClk.
REQ-016 SHALL implement SPI mode 0: mosi sampled at spiClk rise, MSB first; miso changes only at spiClk fall.
REQ-017 SHALL have FSM states IDLE, OPCODE, ADDR, DATA and IGNORE.
REQ-018 SHALL transition IDLE->OPCODE on cs assertion.
REQ-019 SHALL, after 8 bits in OPCODE, go to ADDR if bits[7:1]==DEV_OPCODE, otherwise to IGNORE; bit0=1 means read, bit0=0 means write.
REQ-020 SHALL, after 8 bits in ADDR, latch ptr=addr[3:0] (addr[7:4] ignored) and go to DATA.
REQ-021 SHALL, in DATA, process each complete 8-bit byte: a write commits the byte to ptr; a read shifts out reg[ptr].
REQ-022 SHALL, after each data byte, increment ptr (0x0A wraps to 0x00; 0x0B..0x0F wrap to 0x00) unless IOCON[5] (SEQOP)=1, in which case ptr holds.
REQ-023 SHALL return any state to IDLE on cs deassertion, discarding a partial byte with no commit.
REQ-024 SHALL use register map: 0x00 IODIR (rst 0xFF); 0x01 IPOL; 0x02-0x04 and 0x06-0x08 storage; 0x05 IOCON; 0x09 GPIO; 0x0A OLAT; all others rst 0x00.
REQ-025 SHALL make a GPIO read return gpio_i ^ IPOL, sampled at the transmit load.
REQ-026 SHALL make a GPIO write update OLAT and report wr_addr=0x0A.
REQ-027 SHALL read 0x00 from addresses 0x0B-0x0F and ignore writes to them (no wr_stb).
REQ-028 SHALL commit a write on the sysClk cycle after the synchronized rise of the byte's 8th bit, updating the register and pulsing wr_stb with wr_addr/wr_data in that same cycle.
REQ-029 SHALL, for reads, load the transmit shifter with reg[ptr] on the first synchronized spiClk fall after ADDR or the previous data byte completes; miso = shifter[7], shifted left on each later fall.
REQ-030 SHALL drive miso to 0 in IDLE, OPCODE, ADDR, IGNORE and during write frames.
REQ-031 SHALL give register writes priority over gpio_i sampling in the same cycle; gpio_i itself is not stored.

Reset
REQ-032 SHALL, while reset=0 at a sysClk edge, set FSM to IDLE, clear bit and byte counters, ptr and shifters, apply the register reset values of REQ-024, and set miso=0, wr_stb=0, wr_addr=0, wr_data=0, gpio_o=0x00, iodir_o=0xFF.
REQ-033 SHALL, on reset mid-frame, abort the frame and ignore the remaining bits until the next cs assertion.

Verification
REQ-034 SHALL be verified by: frame 0x40,0x00,0x00 -> one wr_stb, wr_addr=0x0, wr_data=0x00; iodir_o=0x00.
REQ-035 SHALL be verified by: frame 0x40,0x09,0xA5,0x3C -> gpio_o=0xA5 (wr_addr=0xA), then auto-increment ptr 0x0A, gpio_o=0x3C.
REQ-036 SHALL be verified by: IPOL=0x0F, gpio_i=0x55, frame 0x41,0x09,0x00 -> miso byte 0x5A.
REQ-037 SHALL be verified by: frame 0x41,0x0A,x,x,x with OLAT=0x11 and storage 0x00 -> miso 0x11, IODIR value, IPOL value (wrap 0x0A->0x00).
REQ-038 SHALL be verified by: opcode 0x42, or cs raised after 5 data bits -> no wr_stb, miso=0, registers unchanged.
REQ-039 SHALL be verified by: IOCON=0x20, frame 0x40,0x0A,0x01,0x02 -> two wr_stb, both wr_addr=0xA, final gpio_o=0x02.
